// File: rtl/tdc_pkg.sv
// Shared types and widths for the TDC measurement sequencer.
// Optional accumulation mode is enabled by defining TDC_SEQ_ACCUM_EN.
package tdc_pkg;

  localparam int TERM_W  = 8;  // thermometer taps on the vernier line
  localparam int CNT_W   = 4;  // timing counters and decoded stage count
  localparam int RES_W   = 6;  // result width, wide enough for a 4-run sum
  localparam int ACCUM_N = 4;  // runs per request in accumulation mode

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SETTLE,
    SAMPLE,
    HOLD,
    CLEAR
  } state_t;

endpackage

// File: rtl/tdc_therm_decoder.sv
// Combinational thermometer decoder: position of the lowest 0 (or TERM_W
// when all taps are set), bubble detection above that 0, and overflow.
module tdc_therm_decoder
  import tdc_pkg::*;
(
  input  logic [TERM_W-1:0] term_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              bubble_o,
  output logic              ovf_o
);

  logic found;

  // Scan from the first stage upward; any 1 after the first 0 is a bubble.
  always_comb begin
    count_o  = CNT_W'(TERM_W);
    bubble_o = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < TERM_W; i++) begin
      if (!found && !term_i[i]) begin
        found   = 1'b1;
        count_o = CNT_W'(i);
      end else if (found && term_i[i]) begin
        bubble_o = 1'b1;
      end
    end
  end

  assign ovf_o = &term_i;

endmodule

// File: rtl/tdc_sequencer.sv
// TDC measurement sequencer: launches start/stop edges, waits for the
// vernier line to settle, samples the synchronized thermometer, holds the
// decoded result on a valid/ready handshake, then clears the term latches.
// Define TDC_SEQ_ACCUM_EN to run ACCUM_N back-to-back measurements per
// request and report their sum with OR-ed error flags.
module tdc_sequencer
  import tdc_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CLEAR_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              meas_req,
  input  logic [3:0]        cfg_gap,
  output logic              busy,
  output logic              start_launch,
  output logic              stop_launch,
  output logic              dl_clear,
  input  logic [TERM_W-1:0] term_in,
  output logic [RES_W-1:0]  result,
  output logic              err_bubble,
  output logic              err_ovf,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(CLEAR_CYC);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         gap_q, gap_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               clear_q, clear_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               bubble_q, bubble_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic [TERM_W-1:0]  sync1_q, sync2_q;

  logic [CNT_W-1:0]   dec_count;
  logic               dec_bubble;
  logic               dec_ovf;

`ifdef TDC_SEQ_ACCUM_EN
  localparam int RUN_W = $clog2(ACCUM_N);
  logic [RUN_W-1:0]   run_q, run_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic               acc_bub_q, acc_bub_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic [RES_W-1:0]   acc_sum;

  assign acc_sum = acc_q + RES_W'(dec_count);
`endif

  // Two-flop synchronizer on the asynchronous term latches, free-running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= term_in;
      sync2_q <= sync1_q;
    end
  end

  tdc_therm_decoder u_decoder (
    .term_i   (sync2_q),
    .count_o  (dec_count),
    .bubble_o (dec_bubble),
    .ovf_o    (dec_ovf)
  );

  // State and all registered outputs; reset aborts with everything low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      clear_q  <= 1'b0;
      result_q <= '0;
      bubble_q <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef TDC_SEQ_ACCUM_EN
      run_q     <= '0;
      acc_q     <= '0;
      acc_bub_q <= 1'b0;
      acc_ovf_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      clear_q  <= clear_d;
      result_q <= result_d;
      bubble_q <= bubble_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
`ifdef TDC_SEQ_ACCUM_EN
      run_q     <= run_d;
      acc_q     <= acc_d;
      acc_bub_q <= acc_bub_d;
      acc_ovf_q <= acc_ovf_d;
`endif
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    start_d  = start_q;
    stop_d   = stop_q;
    clear_d  = clear_q;
    result_d = result_q;
    bubble_d = bubble_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
`ifdef TDC_SEQ_ACCUM_EN
    run_d     = run_q;
    acc_d     = acc_q;
    acc_bub_d = acc_bub_q;
    acc_ovf_d = acc_ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (meas_req) begin
          busy_d  = 1'b1;
          start_d = 1'b1;
          gap_d   = cfg_gap;
          if (cfg_gap == 4'd0) begin
            stop_d  = 1'b1;
            state_d = SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = GAP;
            cnt_d   = cfg_gap;
          end
        end
      end
      GAP: begin
        if (cnt_q <= CNT_W'(1)) begin
          stop_d  = 1'b1;
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
`ifdef TDC_SEQ_ACCUM_EN
        if (run_q == RUN_W'(ACCUM_N - 1)) begin
          result_d  = acc_sum;
          bubble_d  = acc_bub_q | dec_bubble;
          ovf_d     = acc_ovf_q | dec_ovf;
          valid_d   = 1'b1;
          run_d     = '0;
          acc_d     = '0;
          acc_bub_d = 1'b0;
          acc_ovf_d = 1'b0;
          state_d   = HOLD;
        end else begin
          acc_d     = acc_sum;
          acc_bub_d = acc_bub_q | dec_bubble;
          acc_ovf_d = acc_ovf_q | dec_ovf;
          run_d     = run_q + RUN_W'(1);
          clear_d   = 1'b1;
          cnt_d     = CLEAR_LD;
          state_d   = CLEAR;
        end
`else
        result_d = RES_W'(dec_count);
        bubble_d = dec_bubble;
        ovf_d    = dec_ovf;
        valid_d  = 1'b1;
        state_d  = HOLD;
`endif
      end
      HOLD: begin
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          start_d = 1'b0;
          stop_d  = 1'b0;
          clear_d = 1'b1;
          cnt_d   = CLEAR_LD;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt_q <= CNT_W'(1)) begin
          clear_d = 1'b0;
`ifdef TDC_SEQ_ACCUM_EN
          // A nonzero run index means this clear sits between runs.
          if (run_q != '0) begin
            if (gap_q == 4'd0) begin
              state_d = SETTLE;
              cnt_d   = SETTLE_LD;
            end else begin
              state_d = GAP;
              cnt_d   = gap_q;
            end
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = busy_q;
  assign start_launch = start_q;
  assign stop_launch  = stop_q;
  assign dl_clear     = clear_q;
  assign result       = result_q;
  assign err_bubble   = bubble_q;
  assign err_ovf      = ovf_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_tdc_sequencer.sv
// Directed self-checking bench for tdc_sequencer with a result scoreboard.
// Expectations follow TDC_SEQ_ACCUM_EN when that macro is defined.
module tb_tdc_sequencer;

  localparam int SETTLE = 4;
  localparam int CLEAR  = 2;
`ifdef TDC_SEQ_ACCUM_EN
  localparam int ACC_N = 4;
`else
  localparam int ACC_N = 1;
`endif

  typedef struct {
    logic [5:0] res;
    logic       bub;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       meas_req;
  logic [3:0] cfg_gap;
  logic       busy, start_launch, stop_launch, dl_clear;
  logic [7:0] term_in;
  logic [5:0] result;
  logic       err_bubble, err_ovf, result_valid;
  logic       result_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  tdc_sequencer #(.SETTLE_CYC(SETTLE), .CLEAR_CYC(CLEAR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .meas_req     (meas_req),
    .cfg_gap      (cfg_gap),
    .busy         (busy),
    .start_launch (start_launch),
    .stop_launch  (stop_launch),
    .dl_clear     (dl_clear),
    .term_in      (term_in),
    .result       (result),
    .err_bubble   (err_bubble),
    .err_ovf      (err_ovf),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: count consecutive ones from stage 0.
  function automatic void model(input logic [7:0] t, output int cnt, output bit bub, output bit ovf);
    int tw;
    tw  = int'(t);
    cnt = 0;
    while (cnt < 8 && tw[cnt]) cnt++;
    ovf = (t == 8'hFF);
    bub = (cnt < 8) ? ((tw >> (cnt + 1)) != 0) : 1'b0;
  endfunction

  function automatic logic [31:0] all_outs();
    return {20'd0, busy, start_launch, stop_launch, dl_clear, result, err_bubble, err_ovf, result_valid};
  endfunction

  task automatic run_meas(input logic [7:0] t, input logic [3:0] g, input int hold);
    exp_t e, got;
    int   cnt, k, stop_at, pulses;
    bit   bub, ovf, prev_clr;
    term_in = t;
    cfg_gap = g;
    repeat (3) @(negedge clk);
    model(t, cnt, bub, ovf);
    e.res = 6'(cnt * ACC_N);
    e.bub = bub;
    e.ovf = ovf;
    sb.push_back(e);
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    chk("accept", {busy, start_launch}, 2'b11);
    k = 0; stop_at = -1; pulses = 0; prev_clr = 1'b0;
    while (!result_valid && k < 400) begin
      if (stop_launch && stop_at < 0) stop_at = k;
      if (dl_clear && !prev_clr) pulses++;
      prev_clr = dl_clear;
      @(negedge clk);
      k++;
    end
    chk("valid_timeout", result_valid, 1);
    if (!result_valid) return;
    chk("stop_rise", stop_at, g);
    chk("latency", k, ACC_N * (g + SETTLE + 1) + (ACC_N - 1) * CLEAR);
    chk("mid_clear_pulses", pulses, ACC_N - 1);
    got = sb.pop_front();
    $display("meas term=%02h gap=%0d: result=%0d bub=%0b ovf=%0b (exp %0d %0b %0b)",
             t, g, result, err_bubble, err_ovf, got.res, got.bub, got.ovf);
    chk("result", result, got.res);
    chk("err_bubble", err_bubble, got.bub);
    chk("err_ovf", err_ovf, got.ovf);
    for (int i = 0; i < hold; i++) begin
      meas_req = (i % 2 == 1);
      @(negedge clk);
      chk("hold_stable",
          {result_valid, result, err_bubble, err_ovf, dl_clear, busy, start_launch, stop_launch},
          {1'b1, got.res, got.bub, got.ovf, 1'b0, 3'b111});
    end
    meas_req = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("handshake", {result_valid, start_launch, stop_launch, dl_clear, busy}, 5'b00011);
    for (int c = 1; c < CLEAR; c++) begin
      if (c == CLEAR - 1) meas_req = 1'b1;
      @(negedge clk);
      chk("clear_hold", {dl_clear, busy}, 2'b11);
    end
    @(negedge clk);
    meas_req = 1'b0;
    chk("idle_return", {dl_clear, busy, start_launch, stop_launch, result_valid}, 5'b0);
    @(negedge clk);
    chk("req_ignored", {busy, start_launch}, 2'b00);
  endtask

  initial begin
    bit saw_bad;
    rst_n = 1'b0; meas_req = 1'b0; cfg_gap = 4'd0; term_in = 8'hFF; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 0);

    run_meas(8'h1F, 4'd3, 10);
    run_meas(8'h2F, 4'd0, 0);
    run_meas(8'hFF, 4'd1, 2);
    run_meas(8'h00, 4'd15, 0);
    run_meas(8'h07, 4'd2, 1);

    // Abort a measurement while it sits in GAP.
    term_in = 8'h1F; cfg_gap = 4'd5; meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_in_gap", all_outs(), 0);
    saw_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dl_clear || result_valid || busy) saw_bad = 1'b1;
    end
    $display("abort in GAP: outputs quiet afterwards=%0b", !saw_bad);
    chk("no_activity_after_abort", saw_bad, 0);

    run_meas(8'h0B, 4'd7, 3);
    for (int r = 0; r < 2; r++) begin
      logic [7:0] rt;
      logic [3:0] rg;
      rt = 8'($urandom_range(0, 255));
      rg = 4'($urandom_range(0, 15));
      run_meas(rt, rg, int'($urandom_range(0, 4)));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
